read_cycle: RTL

READ_CYCLE -- requirements
Module: read_cycle

---
 rtl/read_cycle_pkg.sv | 35 +++
 rtl/wait_timer.sv | 25 ++
 rtl/read_cycle.sv | 99 +++++++++
 3 files changed

// File: rtl/read_cycle_pkg.sv
// rtl/read_cycle_pkg.sv - state encodings, default timings and strobe decode for the RTC bus cycle controllers
package read_cycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_ALATCH = 3'd2,
    ST_TURN   = 3'd3,
    ST_READ   = 3'd4,
    ST_RECOV  = 3'd5,
    ST_DONE   = 3'd6
  } rc_state_e;

  localparam int DEF_T_AS  = 4;
  localparam int DEF_T_AH  = 2;
  localparam int DEF_T_RD  = 8;
  localparam int DEF_T_REC = 6;

  // Returns {AD,CS,RD,WR,ad_mux,TS,read_end}; the unused encoding 7 decodes as idle.
  function automatic logic [6:0] strobe_decode(input logic [2:0] st);
    logic [6:0] s;
    case (st)
      3'd0:    s = 7'b1111000;
      3'd1:    s = 7'b0111000;
      3'd2:    s = 7'b1111000;
      3'd3:    s = 7'b1111110;
      3'd4:    s = 7'b1001110;
      3'd5:    s = 7'b1111110;
      3'd6:    s = 7'b1111001;
      default: s = 7'b1111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - 4-bit loadable down-counter that flags when it reaches zero
module wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);

  logic [3:0] cnt;

  // Saturates at zero so idle states leave the flag asserted harmlessly.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign expired = (cnt == 4'd0);

endmodule

// File: rtl/read_cycle.sv
// rtl/read_cycle.sv - multiplexed-bus RTC read cycle sequencer with registered Moore strobes
module read_cycle
  import read_cycle_pkg::*;
#(
  parameter int T_AS  = DEF_T_AS,
  parameter int T_AH  = DEF_T_AH,
  parameter int T_RD  = DEF_T_RD,
  parameter int T_REC = DEF_T_REC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic [7:0] data_in,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       TS,
  output logic       ad_mux,
  output logic       read_end,
  output logic [2:0] state,
  output logic [7:0] data_out
);

  rc_state_e  state_q;
  rc_state_e  state_d;
  logic [6:0] strobe_q;
  logic       tmr_load;
  logic [3:0] tmr_val;
  logic       tmr_end;

  wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_end)
  );

  // The timer is loaded with duration-1 on the edge that enters each timed state.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (in) begin
          state_d  = ST_ADDR;
          tmr_load = 1'b1;
          tmr_val  = 4'(T_AS - 1);
        end
      end
      ST_ADDR: begin
        if (tmr_end) begin
          state_d  = ST_ALATCH;
          tmr_load = 1'b1;
          tmr_val  = 4'(T_AH - 1);
        end
      end
      ST_ALATCH: begin
        if (tmr_end) state_d = ST_TURN;
      end
      ST_TURN: begin
        state_d  = ST_READ;
        tmr_load = 1'b1;
        tmr_val  = 4'(T_RD - 1);
      end
      ST_READ: begin
        if (tmr_end) begin
          state_d  = ST_RECOV;
          tmr_load = 1'b1;
          tmr_val  = 4'(T_REC - 1);
        end
      end
      ST_RECOV: begin
        if (tmr_end) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they change together with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      strobe_q <= strobe_decode(ST_IDLE);
      data_out <= 8'h00;
    end else begin
      state_q  <= state_d;
      strobe_q <= strobe_decode(state_d);
      if (state_q == ST_READ && tmr_end) data_out <= data_in;
    end
  end

  assign {AD, CS, RD, WR, ad_mux, TS, read_end} = strobe_q;
  assign state = state_q;

endmodule
